// File: rtl/load_store_unit_pkg.sv
// Shared types for the memory-stage load/store unit: access sizes, execute control
// bundle, LSU FSM states and alignment helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    BYTE        = 2'd0,
    HALF_WORD   = 2'd1,
    WORD        = 2'd2,
    DOUBLE_WORD = 2'd3
  } mem_access_size_t;

  typedef struct packed {
    logic             data_req;
    mem_access_size_t data_byte;
    logic             data_wr;
    logic             zero_extnd;
  } control_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  // Low address bits forced to the natural alignment of the access size.
  function automatic logic [1:0] natural_lo(mem_access_size_t size, logic [1:0] lo);
    case (size)
      HALF_WORD:         natural_lo = {lo[1], 1'b0};
      WORD, DOUBLE_WORD: natural_lo = 2'b00;
      default:           natural_lo = lo;
    endcase
  endfunction

  function automatic logic misaligned(mem_access_size_t size, logic [1:0] lo);
    misaligned = ((size == HALF_WORD) && lo[0]) || ((size == WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_data_align: combinational byte-enable / store-lane replication and
// load extract with sign or zero extension.
module lsu_data_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]       addr_lo,
  input  mem_access_size_t size,
  input  logic             zero_extnd,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [3:0]       be,
  output logic [XLEN-1:0]  wdata_rep,
  output logic [XLEN-1:0]  rdata_ext
);

  logic [XLEN-1:0] rdata_shift;

  assign rdata_shift = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    rdata_ext = '0;
    case (size)
      BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{(XLEN-8){~zero_extnd & rdata_shift[7]}}, rdata_shift[7:0]};
      end
      HALF_WORD: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{(XLEN-16){~zero_extnd & rdata_shift[15]}}, rdata_shift[15:0]};
      end
      WORD: begin
        be        = 4'hF;
        wdata_rep = wdata;
        rdata_ext = rdata_shift;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request/grant/response data-memory access per
// accepted operation. Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ex_req_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic [1:0]      ex_size_i,
  input  logic            ex_wr_i,
  input  logic            ex_zero_extnd_i,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_rdata_o,
  output logic            wb_err_o
);

  lsu_state_t       state_reg, state_next;
  control_t         ex_ctrl;
  logic             accept, fault, timeout_hit;
  logic [1:0]       ex_lo;

  logic [XLEN-1:0]  addr_reg, wdata_reg, rdata_reg;
  logic [3:0]       be_reg;
  logic [1:0]       lo_reg;
  mem_access_size_t size_reg;
  logic             wr_reg, zx_reg, err_reg;
  logic [31:0]      cnt_reg;

  logic [3:0]       st_be;
  logic [XLEN-1:0]  st_wdata, ld_ext;
  logic [XLEN-1:0]  unused_st_rdata, unused_ld_wdata;
  logic [3:0]       unused_ld_be;

  assign ex_ctrl = '{data_req:   ex_req_i,
                     data_byte:  mem_access_size_t'(ex_size_i),
                     data_wr:    ex_wr_i,
                     zero_extnd: ex_zero_extnd_i};

  assign accept = ex_ctrl.data_req && (state_reg == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign ex_lo = ex_addr_i[1:0];
  assign fault = (ex_ctrl.data_byte == DOUBLE_WORD) || misaligned(ex_ctrl.data_byte, ex_addr_i[1:0]);
`else
  assign ex_lo = natural_lo(ex_ctrl.data_byte, ex_addr_i[1:0]);
  assign fault = (ex_ctrl.data_byte == DOUBLE_WORD);
`endif

  // Counter holds the number of REQ/WAIT cycles already completed.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_reg == TIMEOUT_CYC - 1);

  lsu_data_align #(.XLEN(XLEN)) u_store_align (
    .addr_lo    (ex_lo),
    .size       (ex_ctrl.data_byte),
    .zero_extnd (ex_ctrl.zero_extnd),
    .wdata      (ex_wdata_i),
    .rdata      ('0),
    .be         (st_be),
    .wdata_rep  (st_wdata),
    .rdata_ext  (unused_st_rdata)
  );

  lsu_data_align #(.XLEN(XLEN)) u_load_align (
    .addr_lo    (lo_reg),
    .size       (size_reg),
    .zero_extnd (zx_reg),
    .wdata      ('0),
    .rdata      (mem_rdata_i),
    .be         (unused_ld_be),
    .wdata_rep  (unused_ld_wdata),
    .rdata_ext  (ld_ext)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // A response in the expiry cycle wins; a grant in the expiry cycle does not.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = fault ? RESP : REQ;
      REQ:  if (timeout_hit) state_next = RESP;
            else if (mem_gnt_i) state_next = WAIT;
      WAIT: if (mem_rvalid_i || timeout_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      be_reg    <= '0;
      lo_reg    <= '0;
      size_reg  <= BYTE;
      wr_reg    <= 1'b0;
      zx_reg    <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      addr_reg  <= {ex_addr_i[XLEN-1:2], 2'b00};
      wdata_reg <= st_wdata;
      rdata_reg <= '0;
      be_reg    <= st_be;
      lo_reg    <= ex_lo;
      size_reg  <= ex_ctrl.data_byte;
      wr_reg    <= ex_ctrl.data_wr;
      zx_reg    <= ex_ctrl.zero_extnd;
      err_reg   <= fault;
      cnt_reg   <= '0;
    end else if ((state_reg == REQ) || (state_reg == WAIT)) begin
      cnt_reg <= cnt_reg + 32'd1;
      if ((state_reg == WAIT) && mem_rvalid_i) begin
        if (!wr_reg) rdata_reg <= ld_ext;
      end else if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    ex_ready_o  = (state_reg == IDLE);
    mem_req_o   = (state_reg == REQ);
    mem_addr_o  = (state_reg == REQ) ? addr_reg : '0;
    mem_we_o    = (state_reg == REQ) && wr_reg;
    mem_be_o    = (state_reg == REQ) ? be_reg : 4'b0000;
    mem_wdata_o = (state_reg == REQ) ? wdata_reg : '0;
    wb_valid_o  = (state_reg == RESP);
    wb_err_o    = (state_reg == RESP) && err_reg;
    wb_rdata_o  = (state_reg == RESP) ? rdata_reg : '0;
  end

endmodule
